counter_pulse_driver: RTL and testbench
=======================================

Name: counter_pulse_driver

Overview:
Initiator-side partner for the 4-bit pulse counter. It converts queued commands into single-cycle en/rst pulses aimed at the counter's en/rst inputs. It tracks the expected count in a local reference model and compares that model against the counter's returned count outputs after a fixed latency. It sits between the bench/control logic and the counter-under-test, and flags any divergence.

Parameters:
WIDTH, 4, counter width; the model wraps modulo 2^WIDTH.
CHECK_LAT, 2, cycles from pulse issue to the cycle in which count_in is sampled (minimum 1).
GAP_CYCLES, 1, idle cycles between consecutive pulses of one repeated command (minimum 0).
REP_W, 8, width of cmd_repeat.
ERR_W, 8, width of err_count.

Ports:
GCLK_Pad  in  1  single clock; all state updates on rising edge.
rst_Pad  in  1  synchronous, active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  driver can accept a command; high only in IDLE.
cmd_en  in  1  command requests an en pulse.
cmd_rst  in  1  command requests a counter-reset pulse.
cmd_repeat  in  REP_W  number of pulses to issue; 0 is treated as 1.
en_Pad_o  out  1  en pulse to the counter.
cnt_rst_Pad_o  out  1  reset pulse to the counter.
count_in  in  WIDTH  counter outputs (count0..count3), LSB = count0.
expected  out  WIDTH  reference model value.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle strobe when a command completes.
err_sticky  out  1  set on the first mismatch; cleared only by reset.
err_count  out  ERR_W  mismatch count; saturates at all-ones.

Behaviour:
- Reset (rst_Pad=1 at an edge):
  - State goes to IDLE.
  - All outputs are 0, including expected, err_sticky and err_count.
  - cmd_ready is 0 during the reset cycle and 1 on the first cycle after reset deasserts.
- Reset mid-command aborts the command immediately:
  - No further pulses are issued.
  - No done strobe is produced.
- State machine has four states: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - cmd_ready=1.
  - A command is accepted when cmd_valid && cmd_ready. The driver latches en, rst and repeat (0 becomes 1) into a remaining-pulse counter rem, then moves to ISSUE.
- ISSUE (exactly one cycle):
  - Drives en_Pad_o=cmd_en and cnt_rst_Pad_o=cmd_rst. Both outputs are registered, so each pulse is exactly one cycle wide.
  - Updates the model:
    - rst set: expected <= 0, and rst dominates when en is also set.
    - else en set: expected <= expected+1 mod 2^WIDTH, so 15 -> 0.
    - else: expected is unchanged (check-only command, no pulse).
  - Decrements rem, loads the latency counter with CHECK_LAT, and moves to WAIT.
- WAIT:
  - Pulse outputs are 0.
  - The latency counter decrements each cycle. On the cycle it reaches 1, count_in is compared with expected.
  - On mismatch: err_sticky <= 1 and err_count <= err_count+1, saturating.
  - After the compare:
    - rem == 0: done=1 for one cycle and return to IDLE.
    - else if GAP_CYCLES > 0: go to GAP.
    - else: go to ISSUE.
- GAP: hold GAP_CYCLES cycles with pulses low, then go to ISSUE.
- Command timing:
  - Single-pulse command, accept to done = 1 + CHECK_LAT cycles.
  - N pulses = N*(1+CHECK_LAT) + (N-1)*GAP_CYCLES cycles.
  - Back-to-back commands: cmd_ready rises in the cycle after done, so consecutive ISSUE states are separated by at least one IDLE cycle.
- cmd_valid is ignored while busy; commands are not queued.
- The width of count_in must equal WIDTH. No X propagation: count_in containing X counts as a mismatch in simulation only.

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE, ISSUE, WAIT, GAP);
  - the op encoding constants OP_NONE=00, OP_EN=01, OP_RST=10, OP_BOTH=11;
  - the default WIDTH, CHECK_LAT and GAP_CYCLES.
- One natural sub-module, counter_ref_model: the WIDTH-bit wrap/reset reference model plus comparator, with inputs en, rst, sample and count_in, and outputs expected and mismatch. The FSM and the error counters stay in the top.

Test Plan:
1. Reset then a single en command (repeat=1) with an ideal counter.
   - en_Pad_o high for exactly 1 cycle; expected=1; done 3 cycles after accept (CHECK_LAT=2); err_count=0.
2. en command with repeat=17 from expected=0, GAP_CYCLES=1.
   - 17 pulses, each 4 cycles apart; expected wraps 15 -> 0 and ends at 1; no errors.
3. Command with both en and rst set while expected=5.
   - Both pulses high in the same cycle; expected=0; ideal counter returns 0 -> no error.
4. Counter model deliberately stuck at 3 while 2 en pulses are issued from 0.
   - First compare (expected 1 vs 3): err_sticky=1, err_count=1.
   - Second compare (expected 2 vs 3): err_count=2.
5. rst_Pad asserted during WAIT of a repeat=4 command.
   - Next cycle: IDLE, all outputs 0, no done, no further pulses; cmd_ready=1 the cycle after rst_Pad drops.
6. 260 mismatching compares with ERR_W=8.
   - err_count saturates at 255 and err_sticky stays 1.

Source files
------------

// File: rtl/counter_pulse_driver_pkg.sv
// -----------------------------------------------------------------------------
// counter_pulse_driver_pkg
//   Shared definitions for the counter pulse driver slice:
//     - drv_state_t : driver FSM states (IDLE, ISSUE, WAIT, GAP)
//     - op_t / OP_* : command op encoding, bit0 = en pulse, bit1 = reset pulse
//     - DEF_*       : default counter width, check latency and pulse gap
//     - helpers     : op decode and counter-width sizing
// -----------------------------------------------------------------------------
package counter_pulse_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } drv_state_t;

    typedef logic [1:0] op_t;

    localparam op_t OP_NONE = 2'b00;
    localparam op_t OP_EN   = 2'b01;
    localparam op_t OP_RST  = 2'b10;
    localparam op_t OP_BOTH = 2'b11;

    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_CHECK_LAT  = 2;
    localparam int unsigned DEF_GAP_CYCLES = 1;

    function automatic op_t make_op(input logic en, input logic rst);
        return {rst, en};
    endfunction

    function automatic logic op_has_en(input op_t op);
        return (op == OP_EN) || (op == OP_BOTH);
    endfunction

    function automatic logic op_has_rst(input op_t op);
        return (op == OP_RST) || (op == OP_BOTH);
    endfunction

    // Bits needed to hold 0..max_val, never less than 1.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((64'd1 << w) <= 64'(max_val)))
            w++;
        return w;
    endfunction

endpackage

// File: rtl/counter_pulse_driver_ref_model.sv
// -----------------------------------------------------------------------------
// counter_ref_model
//   Reference model of the WIDTH-bit pulse counter plus its comparator.
//   The model reset dominates the enable; the count wraps modulo 2^WIDTH.
//
//   Ports:
//     clk       in   clock, rising edge
//     clear     in   synchronous clear of the model (driver reset)
//     en        in   advance the model by one
//     rst       in   zero the model (wins over en)
//     sample    in   compare count_in against the model this cycle
//     count_in  in   counter value returned by the counter-under-test
//     expected  out  current model value
//     mismatch  out  sample && count_in differs from expected
// -----------------------------------------------------------------------------
module counter_ref_model #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             rst,
    input  logic             sample,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch
);

    always_ff @(posedge clk) begin
        if (clear || rst)
            expected <= '0;
        else if (en)
            expected <= expected + WIDTH'(1);
    end

    // Structured as "assume mismatch, clear only on a definite match" so an
    // unknown count_in is reported as a mismatch rather than silently passing.
    always_comb begin
        mismatch = 1'b0;
        if (sample) begin
            mismatch = 1'b1;
            if (count_in == expected)
                mismatch = 1'b0;
        end
    end

endmodule

// File: rtl/counter_pulse_driver.sv
// -----------------------------------------------------------------------------
// counter_pulse_driver
//   Turns accepted commands into one-cycle en / reset pulses for a WIDTH-bit
//   pulse counter, tracks the expected count in a reference model, and checks
//   the counter's returned value CHECK_LAT cycles after each pulse.
//
//   Ports:
//     GCLK_Pad       in   clock, all state on the rising edge
//     rst_Pad        in   synchronous active-high reset
//     cmd_valid      in   command offered
//     cmd_ready      out  command can be accepted (IDLE only, registered)
//     cmd_en         in   command wants en pulses
//     cmd_rst        in   command wants counter-reset pulses
//     cmd_repeat     in   pulse count, 0 treated as 1
//     en_Pad_o       out  en pulse to the counter (registered, 1 cycle)
//     cnt_rst_Pad_o  out  reset pulse to the counter (registered, 1 cycle)
//     count_in       in   counter outputs, LSB = count0
//     expected       out  reference model value
//     busy           out  FSM not in IDLE
//     done           out  one-cycle strobe on the final compare of a command
//     err_sticky     out  set on first mismatch, cleared by reset only
//     err_count      out  saturating mismatch count
// -----------------------------------------------------------------------------
module counter_pulse_driver
    import counter_pulse_driver_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned CHECK_LAT  = DEF_CHECK_LAT,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned REP_W      = 8,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             GCLK_Pad,
    input  logic             rst_Pad,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_en,
    input  logic             cmd_rst,
    input  logic [REP_W-1:0] cmd_repeat,
    output logic             en_Pad_o,
    output logic             cnt_rst_Pad_o,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] expected,
    output logic             busy,
    output logic             done,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned LAT_W = cnt_width(CHECK_LAT);
    localparam int unsigned GAP_W = cnt_width(GAP_CYCLES);

    drv_state_t       state_q, state_d;
    op_t              op_q, op_d;
    logic [REP_W-1:0] rem_q;
    logic [LAT_W-1:0] lat_q;
    logic [GAP_W-1:0] gap_q;

    logic accept;
    logic sample;
    logic done_c;
    logic model_en;
    logic model_rst;
    logic mismatch;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        sample  = 1'b0;
        done_c  = 1'b0;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    op_d    = make_op(cmd_en, cmd_rst);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LAT_W'(1)) begin
                    sample = 1'b1;
                    if (rem_q == '0) begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1))
                    state_d = ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    // A reset landing on the final compare cycle aborts the command.
    assign done = done_c && !rst_Pad;

    // ----------------------------------------------------------- datapath
    // Pulse and ready outputs are registered off the next state, so the pulse
    // is high exactly during the ISSUE cycle and ready exactly during IDLE.
    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            op_q          <= OP_NONE;
            rem_q         <= '0;
            lat_q         <= '0;
            gap_q         <= '0;
            cmd_ready     <= 1'b0;
            en_Pad_o      <= 1'b0;
            cnt_rst_Pad_o <= 1'b0;
        end else begin
            op_q          <= op_d;
            cmd_ready     <= (state_d == ST_IDLE);
            en_Pad_o      <= (state_d == ST_ISSUE) && op_has_en(op_d);
            cnt_rst_Pad_o <= (state_d == ST_ISSUE) && op_has_rst(op_d);

            if (accept)
                rem_q <= (cmd_repeat == '0) ? REP_W'(1) : cmd_repeat;
            else if (state_q == ST_ISSUE)
                rem_q <= rem_q - REP_W'(1);

            if (state_q == ST_ISSUE)
                lat_q <= LAT_W'(CHECK_LAT);
            else if (state_q == ST_WAIT)
                lat_q <= lat_q - LAT_W'(1);

            if (state_q == ST_WAIT && state_d == ST_GAP)
                gap_q <= GAP_W'(GAP_CYCLES);
            else if (state_q == ST_GAP)
                gap_q <= gap_q - GAP_W'(1);
        end
    end

    // ------------------------------------------------------ error tracking
    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (mismatch) begin
            err_sticky <= 1'b1;
            if (err_count != '1)
                err_count <= err_count + ERR_W'(1);
        end
    end

    // --------------------------------------------------- reference model
    assign model_en  = (state_q == ST_ISSUE) && op_has_en(op_q);
    assign model_rst = (state_q == ST_ISSUE) && op_has_rst(op_q);

    counter_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref_model (
        .clk      (GCLK_Pad),
        .clear    (rst_Pad),
        .en       (model_en),
        .rst      (model_rst),
        .sample   (sample),
        .count_in (count_in),
        .expected (expected),
        .mismatch (mismatch)
    );

endmodule

// File: tb/tb_counter_pulse_driver.sv
// -----------------------------------------------------------------------------
// tb_counter_pulse_driver
//   Drives commands into counter_pulse_driver with an attached behavioural
//   4-bit counter (optionally forced to a stuck value) and checks pulses,
//   timing, model value and error reporting against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_counter_pulse_driver;

    localparam int unsigned W   = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned GAP = 1;
    localparam int unsigned MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_Pad;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_en;
    logic         cmd_rst;
    logic [7:0]   cmd_repeat;
    logic         en_Pad_o;
    logic         cnt_rst_Pad_o;
    logic [W-1:0] count_in;
    logic [W-1:0] expected;
    logic         busy;
    logic         done;
    logic         err_sticky;
    logic [7:0]   err_count;

    always #5 clk = ~clk;

    counter_pulse_driver #(
        .WIDTH      (W),
        .CHECK_LAT  (LAT),
        .GAP_CYCLES (GAP),
        .REP_W      (8),
        .ERR_W      (8)
    ) dut (
        .GCLK_Pad      (clk),
        .rst_Pad       (rst_Pad),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_en        (cmd_en),
        .cmd_rst       (cmd_rst),
        .cmd_repeat    (cmd_repeat),
        .en_Pad_o      (en_Pad_o),
        .cnt_rst_Pad_o (cnt_rst_Pad_o),
        .count_in      (count_in),
        .expected      (expected),
        .busy          (busy),
        .done          (done),
        .err_sticky    (err_sticky),
        .err_count     (err_count)
    );

    // Counter-under-test: ideal 4-bit counter, output optionally forced.
    logic [W-1:0] cnt_reg;
    bit           stuck;
    logic [W-1:0] stuck_val;

    always @(posedge clk) begin
        if (rst_Pad || cnt_rst_Pad_o)
            cnt_reg <= '0;
        else if (en_Pad_o)
            cnt_reg <= cnt_reg + 1'b1;
    end
    assign count_in = stuck ? stuck_val : cnt_reg;

    // Pulse monitor (sampled on the falling edge).
    int unsigned cyc;
    int unsigned en_hi, rst_hi, both_hi, done_cnt, bad_space, last_pulse;
    bit          have_pulse;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (en_Pad_o)                  en_hi   = en_hi + 1;
        if (cnt_rst_Pad_o)             rst_hi  = rst_hi + 1;
        if (en_Pad_o && cnt_rst_Pad_o) both_hi = both_hi + 1;
        if (done)                      done_cnt = done_cnt + 1;
        if (en_Pad_o || cnt_rst_Pad_o) begin
            if (have_pulse && (cyc - last_pulse != 1 + LAT + GAP))
                bad_space = bad_space + 1;
            have_pulse = 1'b1;
            last_pulse = cyc;
        end
    end

    // Scoreboard state.
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_m  = 0;
    int unsigned err_m  = 0;
    bit          sticky_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic clear_mon();
        en_hi      = 0;
        rst_hi     = 0;
        both_hi    = 0;
        bad_space  = 0;
        have_pulse = 1'b0;
    endtask

    task automatic do_reset();
        rst_Pad   = 1'b1;
        cmd_valid = 1'b0;
        stuck     = 1'b0;
        repeat (2) @(negedge clk);
        rst_Pad = 1'b0;
        @(negedge clk);
        exp_m    = 0;
        err_m    = 0;
        sticky_m = 1'b0;
    endtask

    // Issue one command and check it end to end. With junk set, cmd_valid is
    // held high with random fields while the driver is busy.
    task automatic run_cmd(input logic en, input logic rs, input int unsigned rep, input bit junk);
        int unsigned n, mism, lat_exp, d, w;
        bit got;
        n    = (rep == 0) ? 1 : rep;
        mism = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (rs)      exp_m = 0;
            else if (en) exp_m = (exp_m + 1) % MOD;
            if (stuck && (stuck_val != W'(exp_m))) mism++;
        end
        err_m   = (err_m + mism > 255) ? 255 : err_m + mism;
        if (mism != 0) sticky_m = 1'b1;
        lat_exp = n * (1 + LAT) + (n - 1) * GAP;

        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_cmd", cmd_ready, 1'b1);
        clear_mon();
        cmd_valid  = 1'b1;
        cmd_en     = en;
        cmd_rst    = rs;
        cmd_repeat = 8'(rep);

        d   = 0;
        got = 1'b0;
        while (d < 6000 && !got) begin
            @(negedge clk);
            d++;
            if (done) begin
                got = 1'b1;
            end else if (junk) begin
                cmd_valid  = 1'b1;
                cmd_en     = 1'($urandom);
                cmd_rst    = 1'($urandom);
                cmd_repeat = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("done_seen", got, 1'b1);
        if (got) begin
            chk("latency", d, lat_exp);
            chk("ready_in_done", cmd_ready, 1'b0);
        end
        chk("en_pulses",  en_hi,  en ? n : 0);
        chk("rst_pulses", rst_hi, rs ? n : 0);
        chk("both_pulses", both_hi, (en && rs) ? n : 0);
        chk("pulse_spacing", bad_space, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("ready_after",    cmd_ready, 1'b1);
        chk("busy_after",     busy, 1'b0);
        chk("expected",       expected, exp_m);
        chk("err_count",      err_count, err_m);
        chk("err_sticky",     err_sticky, sticky_m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int unsigned done0;
        rst_Pad    = 1'b1;
        cmd_valid  = 1'b0;
        cmd_en     = 1'b0;
        cmd_rst    = 1'b0;
        cmd_repeat = '0;
        stuck      = 1'b0;
        stuck_val  = '0;
        cyc        = 0;
        done_cnt   = 0;
        clear_mon();

        // Reset state.
        @(negedge clk);
        chk("rst_ready",    cmd_ready, 1'b0);
        chk("rst_en",       en_Pad_o, 1'b0);
        chk("rst_crst",     cnt_rst_Pad_o, 1'b0);
        chk("rst_expected", expected, 0);
        chk("rst_busy",     busy, 1'b0);
        chk("rst_done",     done, 1'b0);
        chk("rst_sticky",   err_sticky, 1'b0);
        chk("rst_errcnt",   err_count, 0);
        @(negedge clk);
        chk("rst_ready_hold", cmd_ready, 1'b0);
        rst_Pad = 1'b0;
        @(negedge clk);
        chk("ready_post_rst", cmd_ready, 1'b1);

        // Single en pulse.
        run_cmd(1'b1, 1'b0, 1, 1'b0);

        // 17 pulses from 0: wraps and ends at 1.
        do_reset();
        run_cmd(1'b1, 1'b0, 17, 1'b0);

        // Bring expected to 5, then en+rst together.
        run_cmd(1'b1, 1'b0, 4, 1'b0);
        chk("expected_is_5", expected, 5);
        run_cmd(1'b1, 1'b1, 1, 1'b0);

        // Repeat 0 behaves as 1; check-only command issues no pulses.
        run_cmd(1'b1, 1'b0, 0, 1'b0);
        run_cmd(1'b0, 1'b0, 2, 1'b0);

        // Counter stuck at 3: two compares, two errors.
        do_reset();
        stuck     = 1'b1;
        stuck_val = 4'd3;
        run_cmd(1'b1, 1'b0, 1, 1'b0);
        run_cmd(1'b1, 1'b0, 1, 1'b0);
        stuck = 1'b0;
        run_cmd(1'b1, 1'b0, 1, 1'b0);

        // Reset during WAIT of a 4-pulse command.
        do_reset();
        clear_mon();
        done0      = done_cnt;
        cmd_valid  = 1'b1;
        cmd_en     = 1'b1;
        cmd_rst    = 1'b0;
        cmd_repeat = 8'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst_Pad = 1'b1;
        @(negedge clk);
        chk("abort_en",       en_Pad_o, 1'b0);
        chk("abort_crst",     cnt_rst_Pad_o, 1'b0);
        chk("abort_expected", expected, 0);
        chk("abort_busy",     busy, 1'b0);
        chk("abort_done",     done, 1'b0);
        chk("abort_ready",    cmd_ready, 1'b0);
        rst_Pad = 1'b0;
        @(negedge clk);
        chk("abort_ready_up", cmd_ready, 1'b1);
        repeat (12) @(negedge clk);
        chk("abort_en_count", en_hi, 1);
        chk("abort_no_done",  done_cnt - done0, 0);
        chk("abort_idle",     busy, 1'b0);
        exp_m    = 0;
        err_m    = 0;
        sticky_m = 1'b0;

        // Error counter saturation: 260 mismatching compares.
        stuck     = 1'b1;
        stuck_val = 4'd7;
        run_cmd(1'b0, 1'b0, 255, 1'b0);
        run_cmd(1'b0, 1'b0, 5, 1'b0);
        chk("sat_count",  err_count, 255);
        chk("sat_sticky", err_sticky, 1'b1);
        stuck = 1'b0;

        // Randomized commands with junk offered while busy.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            stuck     = ($urandom_range(0, 3) == 0);
            stuck_val = 4'($urandom);
            run_cmd(1'($urandom), 1'($urandom), $urandom_range(0, 6), 1'b1);
        end
        stuck = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
